// File: rtl/traffic_pkg.sv
// Shared lamp encodings, colour decode and fault codes for the traffic light monitor.
package traffic_pkg;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  typedef enum logic [1:0] {
    COL_R,
    COL_Y,
    COL_G,
    COL_BAD
  } colour_e;

  localparam logic [2:0] FLT_NONE     = 3'd0;
  localparam logic [2:0] FLT_CONFLICT = 3'd1;
  localparam logic [2:0] FLT_EMERG    = 3'd2;
  localparam logic [2:0] FLT_ENC      = 3'd3;
  localparam logic [2:0] FLT_TRANS    = 3'd4;
  localparam logic [2:0] FLT_GREEN    = 3'd5;
  localparam logic [2:0] FLT_YEL      = 3'd6;

  typedef struct packed {
    logic [2:0] code;
    logic [1:0] dir;
  } fault_t;

  // Lamp triple {R,Y,G} to colour; anything not one-hot is BAD.
  function automatic colour_e decode_lamps(input logic [2:0] lamps);
    colour_e col;
    case (lamps)
      LAMP_R:  col = COL_R;
      LAMP_Y:  col = COL_Y;
      LAMP_G:  col = COL_G;
      default: col = COL_BAD;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/lamp_dir_checker.sv
// Per-direction checker: colour decode, run-length counters, encoding/transition/
// green/yellow checks and completed-green-phase counter.
module lamp_dir_checker
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_GREEN  = 5,
  parameter int unsigned YEL_CYCLES = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       lamps,
  input  logic             hist_v,
  input  logic             emergency_q,
  output logic             enc_fail_c,
  output logic             trans_fail_c,
  output logic             green_fail_c,
  output logic             yel_fail_c,
  output logic [CNT_W-1:0] phases
);

  localparam int unsigned GW = $clog2(MIN_GREEN + 2);
  localparam int unsigned YW = $clog2(YEL_CYCLES + 2);
  localparam logic [GW-1:0] G_SAT   = GW'(MIN_GREEN);
  localparam logic [YW-1:0] Y_EXACT = YW'(YEL_CYCLES);
  localparam logic [YW-1:0] Y_SAT   = YW'(YEL_CYCLES + 1);

  colour_e          col_c;
  colour_e          prev_col_q, prev_col_d;
  logic [GW-1:0]    green_cnt_q, green_cnt_d;
  logic [YW-1:0]    yel_cnt_q, yel_cnt_d;
  logic [CNT_W-1:0] phases_q, phases_d;

  assign col_c  = decode_lamps(lamps);
  assign phases = phases_q;

  // Counters include the current cycle, so an over-long yellow flags on the cycle it overruns.
  always_comb begin
    prev_col_d   = col_c;
    green_cnt_d  = '0;
    yel_cnt_d    = '0;
    phases_d     = phases_q;
    enc_fail_c   = (col_c == COL_BAD);
    trans_fail_c = 1'b0;
    green_fail_c = 1'b0;
    yel_fail_c   = 1'b0;

    if (col_c == COL_G) begin
      if (!hist_v || (prev_col_q != COL_G)) green_cnt_d = GW'(1);
      else if (green_cnt_q != G_SAT)        green_cnt_d = green_cnt_q + GW'(1);
      else                                  green_cnt_d = G_SAT;
    end

    if (col_c == COL_Y) begin
      if (!hist_v || (prev_col_q != COL_Y)) yel_cnt_d = YW'(1);
      else if (yel_cnt_q != Y_SAT)          yel_cnt_d = yel_cnt_q + YW'(1);
      else                                  yel_cnt_d = Y_SAT;
    end

    if (hist_v) begin
      trans_fail_c = ((prev_col_q == COL_G) && (col_c == COL_R) && !emergency_q) ||
                     ((prev_col_q == COL_R) && (col_c == COL_Y)) ||
                     ((prev_col_q == COL_Y) && (col_c == COL_G));
      green_fail_c = (prev_col_q == COL_G) && (col_c != COL_G) &&
                     (green_cnt_q < G_SAT) && !emergency_q;
      yel_fail_c   = ((col_c == COL_Y) && (yel_cnt_d > Y_EXACT)) ||
                     ((prev_col_q == COL_Y) && (col_c != COL_Y) &&
                      (yel_cnt_q != Y_EXACT) && !emergency_q);
      if ((prev_col_q == COL_G) && (col_c == COL_Y)) phases_d = phases_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_col_q  <= COL_BAD;
      green_cnt_q <= '0;
      yel_cnt_q   <= '0;
      phases_q    <= '0;
    end else begin
      prev_col_q  <= prev_col_d;
      green_cnt_q <= green_cnt_d;
      yel_cnt_q   <= yel_cnt_d;
      phases_q    <= phases_d;
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive safety monitor on the traffic light controller lamps: cross-direction
// and emergency checks, priority encode of all checks, sticky first-fault latch.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_GREEN  = 5,
  parameter int unsigned YEL_CYCLES = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Ra,
  input  logic             Ya,
  input  logic             Ga,
  input  logic             Rb,
  input  logic             Yb,
  input  logic             Gb,
  input  logic             emergency,
  input  logic             clear,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic [1:0]       fault_dir,
  output logic             fault_pulse,
  output logic [CNT_W-1:0] phases_a,
  output logic [CNT_W-1:0] phases_b
);

  logic [2:0] lamps_a_c, lamps_b_c;
  logic [1:0] enc_c, trans_c, green_c, yel_c;
  logic       conflict_c, emerg_fail_c, fail_c;
  fault_t     win_c;

  logic       hist_v_q, hist_v_d;
  logic       emergency_q, emergency_d;
  logic       fault_q, fault_d;
  logic       fault_pulse_q, fault_pulse_d;
  fault_t     fault_rec_q, fault_rec_d;

  assign lamps_a_c = {Ra, Ya, Ga};
  assign lamps_b_c = {Rb, Yb, Gb};

  lamp_dir_checker #(
    .MIN_GREEN (MIN_GREEN),
    .YEL_CYCLES(YEL_CYCLES),
    .CNT_W     (CNT_W)
  ) u_dir_a (
    .clk         (clk),
    .reset_n     (reset_n),
    .lamps       (lamps_a_c),
    .hist_v      (hist_v_q),
    .emergency_q (emergency_q),
    .enc_fail_c  (enc_c[0]),
    .trans_fail_c(trans_c[0]),
    .green_fail_c(green_c[0]),
    .yel_fail_c  (yel_c[0]),
    .phases      (phases_a)
  );

  lamp_dir_checker #(
    .MIN_GREEN (MIN_GREEN),
    .YEL_CYCLES(YEL_CYCLES),
    .CNT_W     (CNT_W)
  ) u_dir_b (
    .clk         (clk),
    .reset_n     (reset_n),
    .lamps       (lamps_b_c),
    .hist_v      (hist_v_q),
    .emergency_q (emergency_q),
    .enc_fail_c  (enc_c[1]),
    .trans_fail_c(trans_c[1]),
    .green_fail_c(green_c[1]),
    .yel_fail_c  (yel_c[1]),
    .phases      (phases_b)
  );

  assign fault       = fault_q;
  assign fault_code  = fault_rec_q.code;
  assign fault_dir   = fault_rec_q.dir;
  assign fault_pulse = fault_pulse_q;

  // Lowest code wins; direction bits are OR-ed across A and B for the winning code.
  always_comb begin
    hist_v_d      = 1'b1;
    emergency_d   = emergency;
    conflict_c    = (Ga | Ya) & (Gb | Yb);
    emerg_fail_c  = emergency_q && ((lamps_a_c != LAMP_R) || (lamps_b_c != LAMP_R));
    win_c.code    = FLT_NONE;
    win_c.dir     = 2'b00;

    if (conflict_c) begin
      win_c.code = FLT_CONFLICT;
      win_c.dir  = 2'b11;
    end else if (emerg_fail_c) begin
      win_c.code = FLT_EMERG;
      win_c.dir  = 2'b11;
    end else if (|enc_c) begin
      win_c.code = FLT_ENC;
      win_c.dir  = enc_c;
    end else if (|trans_c) begin
      win_c.code = FLT_TRANS;
      win_c.dir  = trans_c;
    end else if (|green_c) begin
      win_c.code = FLT_GREEN;
      win_c.dir  = green_c;
    end else if (|yel_c) begin
      win_c.code = FLT_YEL;
      win_c.dir  = yel_c;
    end

    fail_c        = (win_c.code != FLT_NONE);
    fault_pulse_d = fail_c;
    fault_d       = fault_q;
    fault_rec_d   = fault_rec_q;
    if (clear) begin
      fault_d     = 1'b0;
      fault_rec_d = '0;
    end else if (!fault_q && fail_c) begin
      fault_d     = 1'b1;
      fault_rec_d = win_c;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_v_q      <= 1'b0;
      emergency_q   <= 1'b0;
      fault_q       <= 1'b0;
      fault_pulse_q <= 1'b0;
      fault_rec_q   <= '0;
    end else begin
      hist_v_q      <= hist_v_d;
      emergency_q   <= emergency_d;
      fault_q       <= fault_d;
      fault_pulse_q <= fault_pulse_d;
      fault_rec_q   <= fault_rec_d;
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed and randomized bench for traffic_light_monitor against a run-length
// reference model of the lamp rules.
module tb_traffic_light_monitor;

  localparam int MIN_GREEN  = 5;
  localparam int YEL_CYCLES = 1;
  localparam logic [2:0] LR = 3'b100;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LG = 3'b001;

  logic        clk;
  logic        reset_n;
  logic        Ra, Ya, Ga, Rb, Yb, Gb;
  logic        emergency, clear;
  logic        fault, fault_pulse;
  logic [2:0]  fault_code;
  logic [1:0]  fault_dir;
  logic [15:0] phases_a, phases_b;

  int checks   = 0;
  int failures = 0;

  logic [2:0]  m_prev_a, m_prev_b;
  int          m_run_a, m_run_b;
  bit          m_hist, m_emq, m_fault, m_pulse;
  logic [2:0]  m_code;
  logic [1:0]  m_dir;
  logic [15:0] m_ph_a, m_ph_b;

  logic [2:0]  ph_a [4];
  logic [2:0]  ph_b [4];
  int unsigned dur;

  traffic_light_monitor #(
    .MIN_GREEN (MIN_GREEN),
    .YEL_CYCLES(YEL_CYCLES),
    .CNT_W     (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .Ra         (Ra),
    .Ya         (Ya),
    .Ga         (Ga),
    .Rb         (Rb),
    .Yb         (Yb),
    .Gb         (Gb),
    .emergency  (emergency),
    .clear      (clear),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_dir  (fault_dir),
    .fault_pulse(fault_pulse),
    .phases_a   (phases_a),
    .phases_b   (phases_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic byte colour(input logic [2:0] l);
    if (l == LR) return "R";
    if (l == LY) return "Y";
    if (l == LG) return "G";
    return "X";
  endfunction

  // Returns {yellow, short_green, transition, encoding} failures for one direction.
  function automatic logic [3:0] dir_fails(input logic [2:0] pl, input logic [2:0] cl,
                                           input int run, input bit hist, input bit emq);
    byte p, c;
    logic [3:0] f;
    int ylen;
    p = colour(pl);
    c = colour(cl);
    f = 4'b0000;
    f[0] = (c == "X");
    if (hist) begin
      f[1] = (p == "G" && c == "R" && !emq) || (p == "R" && c == "Y") || (p == "Y" && c == "G");
      f[2] = (p == "G") && (c != "G") && (run < MIN_GREEN) && !emq;
      ylen = (p == "Y") ? run + 1 : 1;
      f[3] = ((c == "Y") && (ylen > YEL_CYCLES)) ||
             ((p == "Y") && (c != "Y") && (run != YEL_CYCLES) && !emq);
    end
    return f;
  endfunction

  task automatic model_step(input logic [2:0] la, input logic [2:0] lb,
                            input logic em, input logic clr);
    logic [3:0] fa, fb;
    logic [2:0] code;
    logic [1:0] dir;
    bit found;
    fa = dir_fails(m_prev_a, la, m_run_a, m_hist, m_emq);
    fb = dir_fails(m_prev_b, lb, m_run_b, m_hist, m_emq);
    code  = 3'd0;
    dir   = 2'b00;
    found = 1'b0;
    if ((la[0] | la[1]) & (lb[0] | lb[1])) begin
      code = 3'd1; dir = 2'b11;
    end else if (m_emq && (la != LR || lb != LR)) begin
      code = 3'd2; dir = 2'b11;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (!found && (fa[k] | fb[k])) begin
          code  = 3'(k + 3);
          dir   = {fb[k], fa[k]};
          found = 1'b1;
        end
      end
    end
    m_pulse = (code != 3'd0);
    if (clr) begin
      m_fault = 1'b0; m_code = 3'd0; m_dir = 2'b00;
    end else if (!m_fault && m_pulse) begin
      m_fault = 1'b1; m_code = code; m_dir = dir;
    end
    if (m_hist && colour(m_prev_a) == "G" && colour(la) == "Y") m_ph_a++;
    if (m_hist && colour(m_prev_b) == "G" && colour(lb) == "Y") m_ph_b++;
    m_run_a  = (m_hist && colour(la) == colour(m_prev_a)) ? m_run_a + 1 : 1;
    m_run_b  = (m_hist && colour(lb) == colour(m_prev_b)) ? m_run_b + 1 : 1;
    m_prev_a = la;
    m_prev_b = lb;
    m_hist   = 1'b1;
    m_emq    = em;
  endtask

  task automatic cmp_model();
    chk("fault", 32'(fault), 32'(m_fault));
    chk("fault_code", 32'(fault_code), 32'(m_code));
    chk("fault_dir", 32'(fault_dir), 32'(m_dir));
    chk("fault_pulse", 32'(fault_pulse), 32'(m_pulse));
    chk("phases_a", 32'(phases_a), 32'(m_ph_a));
    chk("phases_b", 32'(phases_b), 32'(m_ph_b));
  endtask

  task automatic cycle(input logic [2:0] la, input logic [2:0] lb,
                       input logic em, input logic clr);
    {Ra, Ya, Ga} = la;
    {Rb, Yb, Gb} = lb;
    emergency    = em;
    clear        = clr;
    @(posedge clk);
    model_step(la, lb, em, clr);
    #1;
    cmp_model();
  endtask

  task automatic run(input logic [2:0] la, input logic [2:0] lb, input int n);
    for (int i = 0; i < n; i++) cycle(la, lb, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m_hist = 1'b0; m_emq = 1'b0; m_fault = 1'b0; m_pulse = 1'b0;
    m_code = 3'd0; m_dir = 2'b00; m_ph_a = 16'd0; m_ph_b = 16'd0;
    #1;
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_code", 32'(fault_code), 32'd0);
    chk("rst_dir", 32'(fault_dir), 32'd0);
    chk("rst_pulse", 32'(fault_pulse), 32'd0);
    chk("rst_phases_a", 32'(phases_a), 32'd0);
    chk("rst_phases_b", 32'(phases_b), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic rnd_cycle(input logic [2:0] la, input logic [2:0] lb);
    logic [2:0] a, b;
    logic e, c;
    a = la;
    b = lb;
    if ($urandom_range(39, 0) == 0) a = 3'($urandom);
    if ($urandom_range(39, 0) == 0) b = 3'($urandom);
    if (m_emq && $urandom_range(3, 0) != 0) begin
      a = LR; b = LR;
    end
    e = ($urandom_range(29, 0) == 0);
    c = ($urandom_range(24, 0) == 0);
    cycle(a, b, e, c);
  endtask

  initial begin
    reset_n = 1'b1;
    {Ra, Ya, Ga, Rb, Yb, Gb} = 6'b0;
    emergency = 1'b0;
    clear     = 1'b0;
    ph_a = '{LG, LY, LR, LR};
    ph_b = '{LR, LR, LG, LY};
    #2;

    // Nominal controller cycle
    do_reset();
    run(LG, LR, 6);
    run(LY, LR, 1);
    run(LR, LG, 5);
    run(LR, LY, 1);
    run(LG, LR, 1);
    chk("nominal_fault", 32'(fault), 32'd0);
    chk("nominal_phases_a", 32'(phases_a), 32'd1);
    chk("nominal_phases_b", 32'(phases_b), 32'd1);

    // Cross conflict, then clear
    do_reset();
    run(LG, LR, 2);
    run(LG, LG, 1);
    chk("conflict_pulse", 32'(fault_pulse), 32'd1);
    chk("conflict_fault", 32'(fault), 32'd1);
    chk("conflict_code", 32'(fault_code), 32'd1);
    chk("conflict_dir", 32'(fault_dir), 32'd3);
    run(LG, LR, 1);
    chk("conflict_sticky_code", 32'(fault_code), 32'd1);
    cycle(LG, LR, 1'b0, 1'b1);
    chk("conflict_clear_fault", 32'(fault), 32'd0);

    // Emergency honoured, then ignored
    do_reset();
    run(LG, LR, 2);
    cycle(LG, LR, 1'b1, 1'b0);
    run(LR, LR, 2);
    run(LG, LR, 1);
    chk("emerg_ok_fault", 32'(fault), 32'd0);
    chk("emerg_ok_phases_a", 32'(phases_a), 32'd0);
    run(LG, LR, 2);
    cycle(LG, LR, 1'b1, 1'b0);
    run(LG, LR, 1);
    chk("emerg_bad_code", 32'(fault_code), 32'd2);
    chk("emerg_bad_dir", 32'(fault_dir), 32'd3);

    // Short green
    do_reset();
    run(LG, LR, 3);
    run(LY, LR, 1);
    chk("short_green_code", 32'(fault_code), 32'd5);
    chk("short_green_dir", 32'(fault_dir), 32'd1);

    // Yellow held two cycles
    do_reset();
    run(LG, LR, 5);
    run(LY, LR, 1);
    chk("yel1_fault", 32'(fault), 32'd0);
    run(LY, LR, 1);
    chk("yel2_code", 32'(fault_code), 32'd6);
    chk("yel2_dir", 32'(fault_dir), 32'd1);

    // Y->G, and Y->G with Ra also lit
    do_reset();
    run(LG, LR, 5);
    run(LY, LR, 1);
    run(LG, LR, 1);
    chk("y2g_code", 32'(fault_code), 32'd4);
    chk("y2g_dir", 32'(fault_dir), 32'd1);
    do_reset();
    run(LG, LR, 5);
    run(LY, LR, 1);
    run(3'b101, LR, 1);
    chk("enc_code", 32'(fault_code), 32'd3);
    cycle(LR, LR, 1'b0, 1'b1);
    chk("enc_clear_fault", 32'(fault), 32'd0);
    chk("enc_clear_code", 32'(fault_code), 32'd0);

    // Reset mid B green, release into A green
    do_reset();
    run(LG, LR, 6);
    run(LY, LR, 1);
    run(LR, LG, 2);
    chk("midB_phases_a", 32'(phases_a), 32'd1);
    do_reset();
    run(LG, LR, 1);
    chk("post_rst_fault", 32'(fault), 32'd0);
    chk("post_rst_pulse", 32'(fault_pulse), 32'd0);
    run(LG, LR, 4);
    run(LY, LR, 1);
    run(LR, LG, 1);
    chk("post_rst_phases_a", 32'(phases_a), 32'd1);

    // Randomized controller-like traffic with glitches, emergencies and clears
    do_reset();
    for (int seg = 0; seg < 110; seg++) begin
      if (seg % 37 == 36) do_reset();
      for (int ph = 0; ph < 4; ph++) begin
        if (ph % 2 == 0) dur = $urandom_range(8, 3);
        else             dur = ($urandom_range(5, 0) == 0) ? 2 : 1;
        for (int k = 0; k < int'(dur); k++) rnd_cycle(ph_a[ph], ph_b[ph]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
Passive safety monitor that sits on the lamp outputs of traffic_light_controller. It samples the six lamp lines plus emergency every clock and checks lamp encoding, cross-direction conflicts, legal colour sequencing, minimum green and exact yellow durations, and emergency response. It reports a sticky fault with a first-fault code, and counts completed green phases per direction. It is used in-system as a hardware watchdog and on the bench as a checker.

Parameters:
MIN_GREEN, 5, minimum consecutive green cycles per direction (non-emergency exit)
YEL_CYCLES, 1, exact consecutive yellow cycles required per direction
CNT_W, 16, width of phase counters

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
Ra, Ya, Ga  in  1  direction A lamps (from controller)
Rb, Yb, Gb  in  1  direction B lamps (from controller)
emergency  in  1  same emergency request the controller sees
clear  in  1  synchronous clear of sticky fault state
fault  out  1  sticky fault flag
fault_code  out  3  code of first fault since reset/clear (0 = none)
fault_dir  out  2  direction(s) of first fault: bit0 = A, bit1 = B
fault_pulse  out  1  high for one cycle on every cycle any check fails
phases_a  out  CNT_W  completed legal A green phases, wraps
phases_b  out  CNT_W  completed legal B green phases, wraps

Behaviour:
- Reset: all outputs 0, history invalid (hist_v = 0), counters 0, emergency_q = 0.
- Registered inputs: prev lamps (per dir), emergency_q = emergency delayed 1 cycle, hist_v set 1 cycle after reset release.
- Per-direction colour state: R, Y, G from one-hot lamp triple; any other pattern = BAD.
- Checks per cycle, code = priority (lowest wins on simultaneous failures):
  1 conflict: (Ga|Ya) & (Gb|Yb).
  2 emergency response: emergency_q = 1 and lamps != {Ra,Rb} only (controller lamps lag emergency by exactly 1 cycle).
  3 encoding: direction triple not one-hot.
  4 transition (hist_v only): legal = hold, G->Y, Y->R, R->G; G->R or Y->R early legal only if emergency_q; R->Y, Y->G illegal. BAD prev/current skips check 4.
  5 short green: leaving G with green_cnt < MIN_GREEN and emergency_q = 0.
  6 yellow length: yel_cnt exceeds YEL_CYCLES while still yellow (flag immediately), or leaving Y with yel_cnt != YEL_CYCLES and emergency_q = 0.
- green_cnt/yel_cnt per dir: 1 on first cycle of colour, +1 while held, saturate at MIN_GREEN/YEL_CYCLES+1, cleared on other colour.
- Both A-checks and B-checks evaluate every cycle; fault_dir bits OR-ed across directions for the winning code (conflict/emergency set both bits).
- fault_pulse = any check failing this cycle (registered, 1-cycle latency from sampled lamps).
- fault/fault_code/fault_dir: latched on first failure when fault = 0; held until clear or reset. clear same cycle as new failure: clear wins, failure re-latches next cycle if persistent.
- phases_x += 1 on legal G->Y transition; wraps modulo 2^CNT_W; not incremented on emergency G->R.
- Reset mid-operation: all history discarded; first post-reset cycle performs only checks 1-3.

Decomposition:
- Package traffic_pkg: lamp encoding constants (LAMP_R = 3'b100, LAMP_Y = 3'b010, LAMP_G = 3'b001), colour enum {COL_R, COL_Y, COL_G, COL_BAD}, fault code constants FLT_NONE..FLT_YEL.
- Sub-module lamp_dir_checker (instantiated for A and B): decode, prev colour, green/yellow counters, checks 3-6 flags, phase counter. Top holds checks 1-2, priority encode, sticky latch.

Test Plan:
- Drive controller nominal cycle (Sb = 1, Sa = 0): A green 6, A yellow 1, B green 5, B yellow 1 -> fault stays 0, phases_a = phases_b = 1 after one full cycle.
- Force Ga = 1 and Gb = 1 same cycle -> next cycle fault_pulse = 1, fault = 1, fault_code = 1, fault_dir = 2'b11.
- Emergency high 1 cycle during A green cycle 3 -> lamps go Ra&Rb next cycle, no fault, phases_a unchanged; lamps left green instead -> fault_code = 2.
- A green only 3 cycles then yellow (MIN_GREEN = 5) -> fault_code = 5, fault_dir = 2'b01; yellow held 2 cycles -> fault_code = 6 on second yellow cycle.
- A jumps Y->G -> fault_code = 4; same cycle also Ra = 1 (Ra&Ga) -> fault_code = 3 wins; assert clear -> fault = 0, code = 0.
- Assert reset_n low mid-B-green, release into A green -> no transition fault on first cycle, counters 0.
